miyajiro_program_loader: RTL
============================

Name: miyajiro_program_loader

Overview:
- Boot-time stage directly upstream of the MIYAJIRO_CPU core.
- Takes a serial byte stream from the host-side UART receiver, which delivers one byte per valid pulse.
- Packs the bytes into 32-bit little-endian instruction words and writes them sequentially into instruction memory from address 0.
- Holds the core stalled until loading completes, then raises cpu_run so the core starts fetching at PC 0.

Parameters:
- ADDR_WIDTH, 10, instruction-memory word-address width; capacity MAX_WORDS = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous reset, active-high (asserted = 1 despite the suffix).
- rx_valid  input  1  one-cycle pulse: rx_data holds a new byte.
- rx_data  input  8  received byte.
- imem_we  output  1  instruction-memory write enable, one-cycle pulse.
- imem_addr  output  ADDR_WIDTH  word address for the write.
- imem_wdata  output  32  assembled instruction word.
- cpu_run  output  1  high = core released; low = core held.
- load_err  output  1  sticky error flag.
- words_loaded  output  ADDR_WIDTH+1  count of words written so far.

Behaviour:
- Reset (async, reset_n=1): state=RECV_LEN; all outputs 0; byte index, word count, length register and shift register cleared. Reset mid-load aborts the load; the next frame restarts from the length header.
- Frame format: 4-byte little-endian word count N, then N×4 data bytes (each word little-endian, first byte = bits 7:0).
- States:
  - RECV_LEN: collect 4 bytes into N.
  - RECV_DATA: collect words.
  - DONE.
  - ERROR.
  - CHK (only with the optional feature).
- RECV_LEN, on the 4th byte:
  - N==0 -> DONE.
  - N>MAX_WORDS -> ERROR.
  - Otherwise -> RECV_DATA.
- RECV_DATA:
  - On the cycle after the 4th byte of a word is accepted: imem_we=1 for exactly one cycle, imem_addr=current word index, imem_wdata=packed word. Latency = 1 cycle from the rx_valid edge.
  - words_loaded increments in the same cycle as imem_we.
  - After the write of word N-1 -> DONE, or CHK with the feature.
- DONE: cpu_run=1 from the cycle after the last imem_we and held until reset. rx_valid is ignored.
- ERROR: load_err=1, cpu_run=0, rx_valid ignored until reset.
- A rx_valid that coincides with an imem_we cycle is accepted normally; the packer is double-buffered so there is no byte loss. Back-to-back rx_valid on every cycle must be supported.
- imem_addr never wraps: the N>MAX_WORDS rejection guarantees the index stays < MAX_WORDS. N==MAX_WORDS is legal and writes the last address 2**ADDR_WIDTH-1.

Optional Feature:
- Macro: MIYAJIRO_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data word, state CHK expects one extra byte equal to the XOR of all N×4 data bytes.
  - Match -> DONE.
  - Mismatch -> ERROR.
  - With N==0, the checksum byte is still expected and must be 0x00.
- Undefined: no CHK state; DONE is entered directly after the last write and no trailing byte is consumed.

Decomposition:
- Package miyajiro_loader_pkg:
  - State enum loader_state_t (RECV_LEN, RECV_DATA, CHK, DONE, ERROR).
  - Constants BYTES_PER_WORD=4 and LEN_BYTES=4.
- One sub-module: miyajiro_byte_packer. Shifts bytes into a 32-bit little-endian word, exposes a word_valid pulse plus the word, and carries the 2-bit byte index. It is reused for both the length field and data words.

Test Plan:
- Hold reset_n=1 for 10 cycles, then release -> all outputs 0, state RECV_LEN, cpu_run=0.
- Send N=2 (02 00 00 00), then bytes 13 00 00 00 / 93 00 10 00 -> imem_we pulses with (addr0, 0x00000013) and (addr1, 0x00100093); words_loaded=2; cpu_run=1 one cycle after the 2nd write.
- Send N=0 -> cpu_run=1 with no imem_we (feature off); with the feature on, byte 0x00 is required first.
- With ADDR_WIDTH=10, send N=1025 (01 04 00 00) -> load_err=1, cpu_run=0, later bytes produce no writes. Send N=1024 -> last write goes to addr 0x3FF.
- Assert reset_n after 6 of 8 data bytes, release, then resend a full frame -> the first write after reset is addr 0 and there are no stale partial words.
- Checksum build, N=1, bytes AA 55 0F F0, checksum 0x00 -> DONE. Checksum 0x01 -> load_err=1, yet the word is still written at addr 0.

Source files
------------

// File: rtl/miyajiro_loader_pkg.sv
// Shared types and constants for the MIYAJIRO boot-time program loader.
package miyajiro_loader_pkg;

   typedef enum logic [2:0] {
      RECV_LEN  = 3'd0,
      RECV_DATA = 3'd1,
      CHK       = 3'd2,
      DONE      = 3'd3,
      ERROR     = 3'd4
   } loader_state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int LEN_BYTES      = 4;

   function automatic logic [7:0] fold_byte(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/miyajiro_byte_packer.sv
// Little-endian byte-to-word packer shared by the length header and the data words.
// word_valid_o is combinational so the completed word can be registered on the same edge.
module miyajiro_byte_packer
   import miyajiro_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_data_i,
   output logic        word_valid_o,
   output logic [31:0] word_o
);

   localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

   logic [1:0]  idx_q, idx_d;
   logic [23:0] shift_q, shift_d;

   assign word_valid_o = byte_valid_i && (idx_q == LAST_IDX);
   assign word_o       = {byte_data_i, shift_q};

   // Next-state for the byte index and the three low bytes of the word
   always_comb begin
      idx_d   = idx_q;
      shift_d = shift_q;
      if (byte_valid_i) begin
         case (idx_q)
            2'd0:    shift_d[7:0]   = byte_data_i;
            2'd1:    shift_d[15:8]  = byte_data_i;
            2'd2:    shift_d[23:16] = byte_data_i;
            default: shift_d        = shift_q;
         endcase
         idx_d = idx_q + 2'd1;
      end else begin
         idx_d = idx_q;
      end
   end

   // Byte index and partial-word registers
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         idx_q   <= 2'd0;
         shift_q <= 24'd0;
      end else begin
         idx_q   <= idx_d;
         shift_q <= shift_d;
      end
   end

endmodule

// File: rtl/miyajiro_program_loader.sv
// Loads a length-prefixed UART byte stream into instruction memory, then releases the core.
// Optional trailing XOR checksum byte: define MIYAJIRO_LOADER_CHECKSUM_EN.
module miyajiro_program_loader
   import miyajiro_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [DATA_WIDTH-1:0] imem_wdata,
   output logic                  cpu_run,
   output logic                  load_err,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   localparam logic [31:0]         MAX_WORDS_C = 32'd1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] ONE_C       = (ADDR_WIDTH + 1)'(1);
`ifdef MIYAJIRO_LOADER_CHECKSUM_EN
   localparam loader_state_t END_STATE = CHK;
`else
   localparam loader_state_t END_STATE = DONE;
`endif

   loader_state_t         state_q;
   logic                  imem_we_q;
   logic [ADDR_WIDTH-1:0] imem_addr_q;
   logic [DATA_WIDTH-1:0] imem_wdata_q;
   logic                  cpu_run_q;
   logic                  load_err_q;
   logic [ADDR_WIDTH:0]   words_loaded_q;
   logic [ADDR_WIDTH:0]   len_q;
   logic [ADDR_WIDTH:0]   words_next;
`ifdef MIYAJIRO_LOADER_CHECKSUM_EN
   logic [7:0]            csum_q;
`endif

   logic        pk_valid;
   logic        pk_word_valid;
   logic [31:0] pk_word;

   // Bytes reach the packer only while a header or data word is being collected
   assign pk_valid   = rx_valid && ((state_q == RECV_LEN) || (state_q == RECV_DATA));
   assign words_next = words_loaded_q + ONE_C;

   miyajiro_byte_packer u_packer (
      .clk          (clk),
      .reset_n      (reset_n),
      .byte_valid_i (pk_valid),
      .byte_data_i  (rx_data),
      .word_valid_o (pk_word_valid),
      .word_o       (pk_word)
   );

   // Loader FSM with registered memory-write and core-control outputs
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         state_q        <= RECV_LEN;
         imem_we_q      <= 1'b0;
         imem_addr_q    <= '0;
         imem_wdata_q   <= '0;
         cpu_run_q      <= 1'b0;
         load_err_q     <= 1'b0;
         words_loaded_q <= '0;
         len_q          <= '0;
`ifdef MIYAJIRO_LOADER_CHECKSUM_EN
         csum_q         <= 8'h00;
`endif
      end else begin
         imem_we_q <= 1'b0;
         case (state_q)
            RECV_LEN: begin
               if (pk_word_valid) begin
                  if (pk_word == 32'd0) begin
                     state_q <= END_STATE;
                  end else if (pk_word > MAX_WORDS_C) begin
                     state_q    <= ERROR;
                     load_err_q <= 1'b1;
                  end else begin
                     len_q   <= pk_word[ADDR_WIDTH:0];
                     state_q <= RECV_DATA;
                  end
               end
            end
            RECV_DATA: begin
`ifdef MIYAJIRO_LOADER_CHECKSUM_EN
               if (rx_valid) begin
                  csum_q <= fold_byte(csum_q, rx_data);
               end
`endif
               if (pk_word_valid) begin
                  imem_we_q      <= 1'b1;
                  imem_addr_q    <= words_loaded_q[ADDR_WIDTH-1:0];
                  imem_wdata_q   <= pk_word;
                  words_loaded_q <= words_next;
                  if (words_next == len_q) begin
                     state_q <= END_STATE;
                  end
               end
            end
            CHK: begin
`ifdef MIYAJIRO_LOADER_CHECKSUM_EN
               if (rx_valid) begin
                  if (rx_data == csum_q) begin
                     state_q <= DONE;
                  end else begin
                     state_q    <= ERROR;
                     load_err_q <= 1'b1;
                  end
               end
`else
               state_q    <= ERROR;
               load_err_q <= 1'b1;
`endif
            end
            DONE: begin
               cpu_run_q <= 1'b1;
            end
            ERROR: begin
               load_err_q <= 1'b1;
               cpu_run_q  <= 1'b0;
            end
            default: begin
               state_q    <= ERROR;
               load_err_q <= 1'b1;
               cpu_run_q  <= 1'b0;
            end
         endcase
      end
   end

   assign imem_we      = imem_we_q;
   assign imem_addr    = imem_addr_q;
   assign imem_wdata   = imem_wdata_q;
   assign cpu_run      = cpu_run_q;
   assign load_err     = load_err_q;
   assign words_loaded = words_loaded_q;

endmodule
